uart_rx_pkt_buffer: RTL and testbench



---
 rtl/uart_rx_pkt_buffer.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_pkt_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_buffer.sv
// uart_rx_pkt_buffer
// Buffers bytes from the UART receiver in a small FIFO and releases them as
// short packets on a valid/ready byte stream with an end-of-packet marker.
// A packet is released when MAX_PKT bytes are waiting, or when the line has
// been quiet for IDLE_TIMEOUT cycles while a partial packet is waiting.
`default_nettype none

module uart_rx_pkt_buffer #(
    parameter int DEPTH_LOG2   = 4,
    parameter int MAX_PKT      = 8,
    parameter int IDLE_TIMEOUT = 40
) (
    input  logic                  uart_clk,
    input  logic                  uart_rst_n,
    input  logic                  uart_rx_done,
    input  logic [7:0]            uart_rx_byte,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    output logic                  tx_last,
    input  logic                  tx_ready,
    input  logic                  ovr_clr,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int LEN_W  = $clog2(MAX_PKT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PKT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_PKT);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // Storage is deliberately left unreset; only pointers and counters are.
    logic [7:0]            mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  overrun_reg;

    state_t                state_reg;
    logic                  tx_valid_reg;
    logic [IDLE_W-1:0]     idle_cnt_reg;
    logic [LEN_W-1:0]      pkt_len_reg;
    logic [LEN_W-1:0]      sent_reg;

    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  last_beat;
    logic                  flush_now;
    logic [LEN_W-1:0]      pkt_len_next;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign full  = (count_reg == DEPTH_CNT);
    assign pop   = tx_valid_reg && tx_ready;
    assign push  = uart_rx_done && (!full || pop);
    assign drop  = uart_rx_done && full && !pop;

    // End of packet is known from the beat index alone, so it is stable while stalled.
    assign last_beat = tx_valid_reg && (sent_reg == (pkt_len_reg - LEN_ONE));

    // Size-triggered and timeout-triggered flushes take the same action.
    assign flush_now    = (count_reg >= MAX_CNT) || (idle_cnt_reg == IDLE_LAST);
    assign pkt_len_next = (count_reg >= MAX_CNT) ? LEN_MAX : LEN_W'(count_reg);

    assign tx_valid   = tx_valid_reg;
    assign tx_last    = last_beat;
    // Head entry is shown ahead; gated so the bus reads zero outside a packet.
    assign tx_byte    = tx_valid_reg ? mem[rd_ptr_reg] : 8'h00;
    assign overrun    = overrun_reg;
    assign fifo_count = count_reg;

    // Write the incoming byte into the tail slot.
    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= uart_rx_byte;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            overrun_reg <= 1'b0;
        end else if (drop) begin
            overrun_reg <= 1'b1;
        end else if (ovr_clr) begin
            overrun_reg <= 1'b0;
        end
    end

    // Packetiser: wait for data, collect until full-size or idle, then stream it out.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_reg    <= ST_IDLE;
            tx_valid_reg <= 1'b0;
            idle_cnt_reg <= '0;
            pkt_len_reg  <= '0;
            sent_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_valid_reg <= 1'b0;
                    if (count_reg != '0) begin
                        state_reg    <= ST_COLLECT;
                        idle_cnt_reg <= '0;
                    end
                end

                ST_COLLECT: begin
                    tx_valid_reg <= 1'b0;
                    if (push) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg != IDLE_SAT) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                    if (flush_now) begin
                        state_reg    <= ST_SEND;
                        tx_valid_reg <= 1'b1;
                        pkt_len_reg  <= pkt_len_next;
                        sent_reg     <= '0;
                    end
                end

                ST_SEND: begin
                    // Bytes pushed now land behind this packet; pkt_len is frozen.
                    if (pop) begin
                        sent_reg <= sent_reg + 1'b1;
                        if (last_beat) begin
                            state_reg    <= ST_IDLE;
                            tx_valid_reg <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_pkt_buffer.sv
// Testbench for uart_rx_pkt_buffer: table of packetisation scenarios plus
// directed sequences for idle timeout, overrun, full-with-pop, stalls and reset.
`timescale 1ns/1ps

module tb_uart_rx_pkt_buffer;

    localparam int DEPTH_LOG2   = 4;
    localparam int MAX_PKT      = 8;
    localparam int IDLE_TIMEOUT = 40;

    logic                uart_clk     = 1'b0;
    logic                uart_rst_n   = 1'b0;
    logic                uart_rx_done = 1'b0;
    logic [7:0]          uart_rx_byte = 8'h00;
    logic                tx_ready     = 1'b1;
    logic                ovr_clr      = 1'b0;
    logic                tx_valid;
    logic [7:0]          tx_byte;
    logic                tx_last;
    logic                overrun;
    logic [DEPTH_LOG2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_byte[$];
    logic       cap_last[$];
    logic [7:0] exp_byte[$];
    logic       exp_last[$];

    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_last  = 1'b0;
    int         stall_seen = 0;

    uart_rx_pkt_buffer #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .MAX_PKT     (MAX_PKT),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .uart_clk    (uart_clk),
        .uart_rst_n  (uart_rst_n),
        .uart_rx_done(uart_rx_done),
        .uart_rx_byte(uart_rx_byte),
        .tx_valid    (tx_valid),
        .tx_byte     (tx_byte),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .ovr_clr     (ovr_clr),
        .overrun     (overrun),
        .fifo_count  (fifo_count)
    );

    always #5 uart_clk = ~uart_clk;

    // Scenario table: strobes, first byte, idle cycles between strobes, packet lengths.
    typedef struct {
        int n;
        int start;
        int gap;
        int len0;
        int len1;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        uart_rx_done = 1'b1;
        uart_rx_byte = b;
        tick();
        uart_rx_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((fifo_count != 0 || tx_valid) && k < 400) begin
            tick();
            k++;
        end
        chk({name, "_drain_in_time"}, int'(k < 400), 1);
        tick(2);
    endtask

    task automatic clear_capture();
        cap_byte.delete();
        cap_last.delete();
    endtask

    task automatic compare_stream(input string name);
        chk({name, "_beats"}, cap_byte.size(), exp_byte.size());
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), int'(cap_byte[i]), int'(exp_byte[i]));
            chk($sformatf("%s_last%0d", name, i), int'(cap_last[i]), int'(exp_last[i]));
        end
        exp_byte.delete();
        exp_last.delete();
        clear_capture();
    endtask

    // Beat monitor: records accepted beats and checks that stalled beats hold.
    always @(negedge uart_clk) begin
        if (!uart_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_seen++;
                checks++;
                if (!tx_valid || tx_byte !== prev_byte || tx_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b byte=%02h last=%0b required valid=1 byte=%02h last=%0b",
                             tx_valid, tx_byte, tx_last, prev_byte, prev_last);
                end
            end
            if (tx_valid && tx_ready) begin
                cap_byte.push_back(tx_byte);
                cap_last.push_back(tx_last);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            prev_last  = tx_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 300us");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int run;
        bit order_ok;

        tbl[0] = '{n: 8,  start: 'h41, gap: 0,  len0: 8, len1: 0};
        tbl[1] = '{n: 3,  start: 'h10, gap: 0,  len0: 3, len1: 0};
        tbl[2] = '{n: 11, start: 'h20, gap: 0,  len0: 8, len1: 3};
        tbl[3] = '{n: 1,  start: 'h80, gap: 0,  len0: 1, len1: 0};
        tbl[4] = '{n: 16, start: 'h90, gap: 0,  len0: 8, len1: 8};
        tbl[5] = '{n: 5,  start: 'hA0, gap: 10, len0: 5, len1: 0};
        tbl[6] = '{n: 9,  start: 'hB0, gap: 1,  len0: 8, len1: 1};

        // Reset state
        #2;
        chk("rst_tx_valid",   int'(tx_valid),   0);
        chk("rst_tx_last",    int'(tx_last),    0);
        chk("rst_tx_byte",    int'(tx_byte),    0);
        chk("rst_overrun",    int'(overrun),    0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        tick(3);
        uart_rst_n = 1'b1;
        tick(2);
        chk("post_rst_fifo_count", int'(fifo_count), 0);
        chk("post_rst_tx_valid",   int'(tx_valid),   0);

        // Table-driven packetisation scenarios with tx_ready held high
        tx_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            clear_capture();
            for (int j = 0; j < tbl[v].n; j++) begin
                strobe(8'(tbl[v].start + j));
                if (tbl[v].gap > 0) tick(tbl[v].gap);
            end
            wait_drain($sformatf("vec%0d", v));
            for (int j = 0; j < tbl[v].n; j++) begin
                exp_byte.push_back(8'(tbl[v].start + j));
                exp_last.push_back((j == tbl[v].len0 - 1) || (j == tbl[v].len0 + tbl[v].len1 - 1));
            end
            $display("vec %0d: %0d strobes from 0x%02h, %0d beats captured",
                     v, tbl[v].n, tbl[v].start, cap_byte.size());
            compare_stream($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_fifo_count", v), int'(fifo_count), 0);
            chk($sformatf("vec%0d_overrun", v),    int'(overrun),    0);
        end

        // Idle timeout: nothing for IDLE_TIMEOUT-1 cycles, first beat visible IDLE_TIMEOUT cycles after the last strobe
        clear_capture();
        strobe(8'h10);
        strobe(8'h11);
        strobe(8'h12);
        k = 0;
        while (!tx_valid && k < 100) begin
            tick();
            k++;
        end
        chk("idle_timeout_latency", k, IDLE_TIMEOUT);
        wait_drain("idle");
        exp_byte = '{8'h10, 8'h11, 8'h12};
        exp_last = '{1'b0, 1'b0, 1'b1};
        compare_stream("idle");
        $display("idle timeout sequence: first beat after %0d cycles", k);

        // Overrun: 17 strobes while stalled, last one dropped
        clear_capture();
        tx_ready = 1'b0;
        for (int j = 0; j < 17; j++) strobe(8'(j));
        tick(2);
        chk("ovr_fifo_count", int'(fifo_count), 16);
        chk("ovr_flag",       int'(overrun),    1);
        chk("ovr_head_valid", int'(tx_valid),   1);
        chk("ovr_head_byte",  int'(tx_byte),    0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        // Drop and clear together: flag ends set
        ovr_clr = 1'b1;
        strobe(8'h77);
        ovr_clr = 1'b0;
        chk("ovr_drop_beats_clr", int'(overrun), 1);
        chk("ovr_drop_count",     int'(fifo_count), 16);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared2", int'(overrun), 0);

        // Full FIFO with push and pop in the same cycle
        tx_ready = 1'b1;
        strobe(8'h55);
        chk("full_pushpop_count",   int'(fifo_count), 16);
        chk("full_pushpop_overrun", int'(overrun),    0);
        wait_drain("full");
        for (int j = 0; j < 16; j++) begin
            exp_byte.push_back(8'(j));
            exp_last.push_back(j == 7 || j == 15);
        end
        exp_byte.push_back(8'h55);
        exp_last.push_back(1'b1);
        $display("overrun/full sequence: %0d beats captured", cap_byte.size());
        compare_stream("full");
        chk("full_overrun_end", int'(overrun), 0);

        // Random back-pressure during SEND
        clear_capture();
        stall_seen = 0;
        fork
            begin
                for (int j = 0; j < 20; j++) begin
                    strobe(8'(8'hC0 + j));
                    tick(2);
                end
            end
            begin
                repeat (150) begin
                    tx_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                tx_ready = 1'b1;
            end
        join
        wait_drain("rand");
        chk("rand_beats", cap_byte.size(), 20);
        order_ok = 1'b1;
        run = 0;
        for (int i = 0; i < cap_byte.size() && i < 20; i++) begin
            if (cap_byte[i] != 8'(8'hC0 + i)) order_ok = 1'b0;
            run++;
            if (run > MAX_PKT) order_ok = 1'b0;
            if (cap_last[i]) run = 0;
        end
        chk("rand_order_and_len", int'(order_ok), 1);
        if (cap_last.size() > 0) chk("rand_final_last", int'(cap_last[cap_last.size() - 1]), 1);
        chk("rand_stalls_seen", int'(stall_seen > 0), 1);
        $display("random back-pressure: %0d beats, %0d stalled cycles", cap_byte.size(), stall_seen);
        clear_capture();

        // Reset in the middle of a stalled packet with overrun set
        tx_ready = 1'b0;
        for (int j = 0; j < 17; j++) strobe(8'(8'h30 + j));
        tick(2);
        tx_ready = 1'b1;
        tick(7);
        tx_ready = 1'b0;
        chk("pre_rst_valid", int'(tx_valid), 1);
        chk("pre_rst_last",  int'(tx_last),  1);
        chk("pre_rst_byte",  int'(tx_byte),  'h37);
        chk("pre_rst_ovr",   int'(overrun),  1);
        @(posedge uart_clk);
        #3;
        uart_rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid",   int'(tx_valid),   0);
        chk("mid_rst_tx_last",    int'(tx_last),    0);
        chk("mid_rst_tx_byte",    int'(tx_byte),    0);
        chk("mid_rst_overrun",    int'(overrun),    0);
        chk("mid_rst_fifo_count", int'(fifo_count), 0);
        tick(2);
        uart_rst_n = 1'b1;
        clear_capture();
        tx_ready = 1'b1;
        tick(80);
        chk("after_rst_no_beats",   cap_byte.size(),  0);
        chk("after_rst_fifo_count", int'(fifo_count), 0);
        chk("after_rst_tx_valid",   int'(tx_valid),   0);
        $display("reset mid-packet: %0d beats after release", cap_byte.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
